// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Purpose:
//   Byte FIFO that feeds a downstream UART transmitter one frame at a time.
//   Bytes written by the producer are queued in a circular buffer. A small
//   FSM (IDLE -> LOAD -> LAUNCH -> WAIT) pops one byte and presents it on
//   tx_data. It then pulses tx_launch_n low for one cycle. After that it waits
//   FRAME_CYCLES cycles so the transmitter can finish the frame before the
//   next byte is launched.
//
// Parameters:
//   DEPTH_LOG2   : FIFO depth is 2**DEPTH_LOG2 bytes (must be >= 1).
//   FRAME_CYCLES : clk_Tx cycles reserved per UART frame (must be >= 1).
//
// Ports:
//   clk_Tx       in   clock, all state changes on its rising edge
//   reset        in   asynchronous, active-low reset
//   wr_en        in   byte write strobe (active high)
//   wr_data[7:0] in   byte to queue
//   full         out  FIFO holds 2**DEPTH_LOG2 bytes (registered)
//   empty        out  FIFO holds 0 bytes (registered)
//   level        out  FIFO occupancy, DEPTH_LOG2+1 bits (registered)
//   tx_data[7:0] out  byte presented to the transmitter, held between loads
//   tx_launch_n  out  active-low one-cycle launch strobe
//   busy         out  high whenever the FSM is not in IDLE
//   ovf_err      out  sticky overflow flag
//
// Build option:
//   UART_TX_FEEDER_OVF_STICKY_EN - when defined, ovf_err is set by any write
//   dropped because the FIFO was full, and only reset clears it. When the
//   macro is undefined, ovf_err is tied low and no overflow register exists.
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int FRAME_CYCLES = 114600
) (
  input  logic                clk_Tx,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic [7:0]          tx_data,
  output logic                tx_launch_n,
  output logic                busy,
  output logic                ovf_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Counter only has to reach FRAME_CYCLES-1 (17 bits for the default).
  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   w_level_next;
  logic                  r_full;
  logic                  r_empty;
  logic [7:0]            r_tx_data;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_wr_ok;
  logic                  w_pop;
  logic                  w_busy;
  logic                  w_launch_n;

  // A write is judged only against the registered full flag. A write while
  // full is lost even if LOAD frees a slot in the same cycle.
  assign w_wr_ok = wr_en & ~r_full;
  // LOAD is only entered from IDLE with a non-empty FIFO, and nothing else
  // pops, so popping in LOAD can never underflow.
  assign w_pop   = (r_state == LOAD);

  // ---------------------------------------------------------------------------
  // FIFO storage. There is no reset on the array, so it maps onto RAM. A read
  // never hits the slot being written: a write only lands when the FIFO is not
  // full, and a pop only happens when it is not empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_Tx) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_wr_ok, w_pop})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;  // idle, or write+pop cancel out
    endcase
  end

  // Pointers wrap naturally at 2**DEPTH_LOG2. The flags are computed from
  // the next level, so they are registered alongside it.
  always_ff @(posedge clk_Tx or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  // Registered read. The byte popped in LOAD is held until the next LOAD.
  always_ff @(posedge clk_Tx or negedge reset) begin
    if (!reset) begin
      r_tx_data <= 8'h00;
    end else if (w_pop) begin
      r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Launch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_Tx or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The outputs are decoded from the state register only. Because of this,
  // reset removes a pending strobe at once, and the strobe lasts exactly one
  // cycle.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_launch_n   = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (!r_empty) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_state_next = LAUNCH;
      end
      LAUNCH: begin
        w_launch_n   = 1'b0;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Frame counter. It is cleared in LAUNCH, so every WAIT period starts at 0
  // and lasts exactly FRAME_CYCLES cycles. The launch-to-launch spacing is
  // therefore FRAME_CYCLES+3 cycles (WAIT, IDLE, LOAD, LAUNCH).
  always_ff @(posedge clk_Tx or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef UART_TX_FEEDER_OVF_STICKY_EN
  logic r_ovf_err;

  always_ff @(posedge clk_Tx or negedge reset) begin
    if (!reset) begin
      r_ovf_err <= 1'b0;
    end else if (wr_en && r_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
`else
  assign ovf_err = 1'b0;
`endif

  assign full        = r_full;
  assign empty       = r_empty;
  assign level       = r_level;
  assign tx_data     = r_tx_data;
  assign tx_launch_n = w_launch_n;
  assign busy        = w_busy;

  // ---------------------------------------------------------------------------
  // Sanity properties (simulation only)
  // ---------------------------------------------------------------------------
  a_load_has_data : assert property (@(posedge clk_Tx) disable iff (!reset)
    (r_state == LOAD) |-> !r_empty);
  a_level_bound : assert property (@(posedge clk_Tx) disable iff (!reset)
    r_level <= LVL_FULL);
  a_flags_match : assert property (@(posedge clk_Tx) disable iff (!reset)
    (r_full == (r_level == LVL_FULL)) && (r_empty == (r_level == '0)));

endmodule
